// File: rtl/debounced_magnitude_comparator_if.sv
// Operand/indicator bundle for debounced_magnitude_comparator.
// The DIFF field exists only when CMP_ABSDIFF_EN is defined.
interface debounced_magnitude_comparator_if #(
  parameter int WIDTH = 1
);
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             hold;
  logic             lt;
  logic             eq;
  logic             gt;
  logic             valid;
  logic             changed;
`ifdef CMP_ABSDIFF_EN
  logic [WIDTH:0]   diff;
`endif

  modport master (
    output a, b, hold,
`ifdef CMP_ABSDIFF_EN
    input  diff,
`endif
    input  lt, eq, gt, valid, changed
  );

  modport slave (
    input  a, b, hold,
`ifdef CMP_ABSDIFF_EN
    output diff,
`endif
    output lt, eq, gt, valid, changed
  );
endinterface

// File: rtl/debounced_magnitude_comparator.sv
// Synchronised, debounced WIDTH-bit magnitude comparator with freeze and change pulse.
// Optional macro CMP_ABSDIFF_EN adds a registered |A-B| output (bus.diff).
module debounced_magnitude_comparator #(
  parameter int WIDTH           = 1,
  parameter int DEBOUNCE_CYCLES = 12000,
  parameter bit SIGNED          = 1'b0
) (
  input logic clk,
  input logic rst,
  debounced_magnitude_comparator_if.slave bus
);
  localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {INIT, RUN, FROZEN} state_t;

  // Index 0 carries operand A, index 1 carries operand B.
  logic [1:0][WIDTH-1:0] sync1, sync2, cand, stable;
  logic [1:0][CNT_W-1:0] cnt;
  logic [1:0]            qual;
  logic                  hold_meta, hold_sync;

  state_t     state, state_next;
  logic       load_result, track_change, both_qual;
  logic       lt_c, eq_c, gt_c;
  logic [2:0] result;
  logic       valid, changed;

  // NOTE: every register here, synchroniser stages included, clears on the async reset edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1     <= '0;
      sync2     <= '0;
      hold_meta <= 1'b0;
      hold_sync <= 1'b0;
    end else begin
      sync1     <= {bus.b, bus.a};
      sync2     <= sync1;
      hold_meta <= bus.hold;
      hold_sync <= hold_meta;
    end
  end

  // Whole-vector debounce: any bit change restarts the count, the count saturates once accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cand   <= '0;
      stable <= '0;
      cnt    <= '0;
      qual   <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] != cand[i]) begin
          cand[i] <= sync2[i];
          cnt[i]  <= '0;
        end else if (cnt[i] == CNT_LAST) begin
          stable[i] <= cand[i];
          qual[i]   <= 1'b1;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  assign both_qual = qual[0] & qual[1];

  // NOTE: combinational blocks assign every output a default first so no latch is inferred.
  always_comb begin
    lt_c = 1'b0;
    gt_c = 1'b0;
    if (SIGNED) begin
      lt_c = $signed(stable[0]) < $signed(stable[1]);
      gt_c = $signed(stable[0]) > $signed(stable[1]);
    end else begin
      lt_c = stable[0] < stable[1];
      gt_c = stable[0] > stable[1];
    end
  end

  assign eq_c = (stable[0] == stable[1]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= INIT;
    else     state <= state_next;
  end

  // A HOLD seen in INIT is ignored; freezing only starts from RUN.
  always_comb begin
    state_next = state;
    unique case (state)
      INIT:    if (both_qual)  state_next = RUN;
      RUN:     if (hold_sync)  state_next = FROZEN;
      FROZEN:  if (!hold_sync) state_next = RUN;
      default:                 state_next = INIT;
    endcase
  end

  always_comb begin
    load_result  = 1'b0;
    track_change = 1'b0;
    unique case (state)
      INIT:    load_result = both_qual;
      RUN: begin
        load_result  = 1'b1;
        track_change = 1'b1;
      end
      default: ;
    endcase
  end

`ifdef CMP_ABSDIFF_EN
  logic [WIDTH:0] ext_a, ext_b, diff_c, diff;
  assign ext_a  = SIGNED ? {stable[0][WIDTH-1], stable[0]} : {1'b0, stable[0]};
  assign ext_b  = SIGNED ? {stable[1][WIDTH-1], stable[1]} : {1'b0, stable[1]};
  assign diff_c = gt_c ? (ext_a - ext_b) : (ext_b - ext_a);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)              diff <= '0;
    else if (load_result) diff <= diff_c;
  end

  assign bus.diff = diff;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result  <= '0;
      valid   <= 1'b0;
      changed <= 1'b0;
    end else begin
      changed <= 1'b0;
      if (load_result) begin
        result  <= {lt_c, eq_c, gt_c};
        valid   <= 1'b1;
        // track_change is only high in RUN, where VALID is already set; this also covers FROZEN->RUN.
        changed <= track_change && ({lt_c, eq_c, gt_c} != result);
      end
    end
  end

  assign bus.lt      = result[2];
  assign bus.eq      = result[1];
  assign bus.gt      = result[0];
  assign bus.valid   = valid;
  assign bus.changed = changed;
endmodule
